// File: rtl/ysyx_23060075_mem_arbiter.sv
// ysyx_23060075_mem_arbiter
// Shares the single data-memory port between the IFU (read-only) and the LSU
// (read/write). Only one transaction is in flight at a time:
// IDLE -> REQ -> WAIT -> RESP -> IDLE.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ifu_req_*/ifu_addr          IFU request channel (valid/ready)
//   ifu_resp_*/ifu_rdata        IFU response channel (valid/ready)
//   lsu_req_*/lsu_addr/wen/wdata/mask  LSU request channel (valid/ready)
//   lsu_resp_*/lsu_rdata        LSU response channel (lsu_rdata is 0 for writes)
//   mem_req_*/mem_addr/wdata/mask/wen  registered request to memory
//   mem_resp_*/mem_rdata        memory response channel
//
// Optional feature
//   YSYX_23060075_ARB_RR_EN  defined: round-robin tie-break (last_grant register)
//                            undefined: fixed priority, LSU wins ties
//
// Timing notes
//   Every output is a function of registered state only, except
//   ifu/lsu_req_ready, which also depend on the two req_valid inputs.
//   mem_resp_valid is ignored outside WAIT.
module ysyx_23060075_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // IFU
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0] ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  // LSU
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic [MASK_WIDTH-1:0] lsu_mask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  // memory
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [MASK_WIDTH-1:0] mem_mask,
  output logic                  mem_wen,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] mask;
    logic                  wen;
  } req_t;

  state_t                state, state_nxt;
  logic                  owner;      // 0 = IFU, 1 = LSU
  req_t                  req_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  grant_lsu, grant_ifu, accept;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef YSYX_23060075_ARB_RR_EN
  logic last_grant;  // 0 = IFU, 1 = LSU; reset to IFU so LSU wins the first tie

  // LSU wins unless it competes with the IFU and was the last one served.
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b0;
    else if (accept) last_grant <= grant_lsu;
  end
`else
  assign grant_lsu = lsu_req_valid;
`endif

  assign grant_ifu = ifu_req_valid & ~grant_lsu;
  assign accept    = (state == S_IDLE) & (ifu_req_valid | lsu_req_valid);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept)         state_nxt = S_REQ;
      S_REQ:  if (mem_req_ready)  state_nxt = S_WAIT;
      S_WAIT: if (mem_resp_valid) state_nxt = S_RESP;
      S_RESP: if (owner ? lsu_resp_ready : ifu_resp_ready) state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
      end
      S_REQ:  mem_req_valid  = 1'b1;
      S_WAIT: mem_resp_ready = 1'b1;
      S_RESP: begin
        ifu_resp_valid = ~owner;
        lsu_resp_valid = owner;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request fields latched only on accept, response only in WAIT
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner   <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        owner <= grant_lsu;
        if (grant_lsu) begin
          req_q.addr  <= lsu_addr;
          req_q.wdata <= lsu_wdata;
          req_q.mask  <= lsu_mask;
          req_q.wen   <= lsu_wen;
        end else begin
          // IFU fetches are always full-width reads.
          req_q.addr  <= ifu_addr;
          req_q.wdata <= '0;
          req_q.mask  <= '1;
          req_q.wen   <= 1'b0;
        end
      end
      if (state == S_WAIT && mem_resp_valid)
        rdata_q <= req_q.wen ? '0 : mem_rdata;
    end
  end

  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_mask  = req_q.mask;
  assign mem_wen   = req_q.wen;
  assign ifu_rdata = rdata_q;
  assign lsu_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_23060075_mem_arbiter.sv
// Self-checking bench for ysyx_23060075_mem_arbiter: a memory model answers
// requests, expected memory requests and master responses are queued by the
// stimulus and popped by the memory model / response monitor.
module tb_ysyx_23060075_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_mask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;

  ysyx_23060075_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_wen(mem_wen),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic lsu; logic [31:0] data; } resp_t;
  typedef struct packed { logic [31:0] addr; logic wen; logic [31:0] wdata; logic [3:0] mask; } mreq_t;
  resp_t exp_q[$];
  mreq_t exp_mq[$];

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model
  // ---------------------------------------------------------------------------
  logic        mem_rdy_en = 1'b1;
  int          mem_lat    = 0;
  logic        model_rv   = 1'b0;
  logic [31:0] model_data = '0;
  logic        spur_rv    = 1'b0;
  logic [31:0] spur_data  = '0;

  assign mem_req_ready  = mem_rdy_en;
  assign mem_resp_valid = model_rv | spur_rv;
  assign mem_rdata      = model_rv ? model_data : spur_data;

  function automatic logic [31:0] mem_img(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0413;
      32'h8000_0004: return 32'h0000_0513;
      32'h8000_2000: return 32'h1111_2222;
      32'h8000_2004: return 32'h3333_4444;
      32'h8000_2008: return 32'h5555_6666;
      32'h8000_200C: return 32'h7777_8888;
      default:       return 32'hDEAD_0000;
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        logic [31:0] rd;
        logic        abort;
        logic        done;
        mreq_t       e;
        if (exp_mq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL mem_req_unexpected: got addr %0h expected none", mem_addr);
        end else begin
          e = exp_mq.pop_front();
          chk("mem_addr", mem_addr, e.addr);
          chk("mem_wen", mem_wen, e.wen);
          chk("mem_wdata", mem_wdata, e.wdata);
          chk("mem_mask", mem_mask, e.mask);
        end
        // Garbage on writes: the arbiter must return 0 to the LSU regardless.
        rd = mem_wen ? 32'hA5A5_A5A5 : mem_img(mem_addr);
        @(posedge clk); #1;
        abort = 1'b0;
        for (int k = 0; k < mem_lat; k++) begin
          @(posedge clk); #1;
          if (!rst_n) abort = 1'b1;
        end
        if (!rst_n) abort = 1'b1;
        if (!abort) begin
          model_rv = 1'b1; model_data = rd;
          done = 1'b0;
          for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            if (mem_resp_ready) done = 1'b1;
          end
          chk("mem_resp_handshake", done, 1'b1);
          @(posedge clk); #1;
          model_rv = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor / scoreboard
  // ---------------------------------------------------------------------------
  task automatic pop_resp(input logic lsu, input logic [31:0] data);
    resp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_unexpected: got owner %0d data %0h expected none", lsu, data);
    end else begin
      e = exp_q.pop_front();
      chk("resp_owner", lsu, e.lsu);
      chk("resp_data", data, e.data);
    end
  endtask

  initial begin
    logic        m_hold = 1'b0, ri = 1'b0, rl = 1'b0;
    logic [68:0] m_save = '0;
    logic [31:0] r_save = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_hold = 1'b0; ri = 1'b0; rl = 1'b0;
      end else begin
        if (m_hold)
          chk("mem_req_hold", {mem_req_valid, mem_addr, mem_wdata, mem_mask, mem_wen}, {1'b1, m_save});
        if (ri) chk("ifu_resp_hold", {ifu_resp_valid, ifu_rdata}, {1'b1, r_save});
        if (rl) chk("lsu_resp_hold", {lsu_resp_valid, lsu_rdata}, {1'b1, r_save});
        m_hold = mem_req_valid && !mem_req_ready;
        m_save = {mem_addr, mem_wdata, mem_mask, mem_wen};
        ri     = ifu_resp_valid && !ifu_resp_ready;
        rl     = lsu_resp_valid && !lsu_resp_ready;
        r_save = ri ? ifu_rdata : lsu_rdata;
        if (ifu_resp_valid || lsu_resp_valid)
          chk("resp_onehot", ifu_resp_valid & lsu_resp_valid, 1'b0);
        if (ifu_resp_valid && ifu_resp_ready) pop_resp(1'b0, ifu_rdata);
        if (lsu_resp_valid && lsu_resp_ready) pop_resp(1'b1, lsu_rdata);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic push_exp(input logic lsu, input logic [31:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] mk, input logic [31:0] rd);
    exp_mq.push_back('{addr: a, wen: w, wdata: wd, mask: mk});
    exp_q.push_back('{lsu: lsu, data: rd});
  endtask

  task automatic set_lsu(input logic [31:0] a, input logic w, input logic [31:0] wd, input logic [3:0] mk);
    lsu_addr = a; lsu_wen = w; lsu_wdata = wd; lsu_mask = mk;
  endtask

  // Present one request and hold it until accepted; acc = cycle of acceptance.
  task automatic issue(input logic lsu, input logic [31:0] a, input logic w,
                       input logic [31:0] wd, input logic [3:0] mk, output int acc);
    logic ok = 1'b0;
    acc = -1;
    if (lsu) begin set_lsu(a, w, wd, mk); lsu_req_valid = 1'b1; end
    else begin ifu_addr = a; ifu_req_valid = 1'b1; end
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (lsu ? lsu_req_ready : ifu_req_ready) begin ok = 1'b1; acc = cyc; end
    end
    chk("accept_timeout", ok, 1'b1);
    @(posedge clk); #1;
    if (lsu) lsu_req_valid = 1'b0; else ifu_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || exp_mq.size() != 0); t++) @(negedge clk);
    chk("drain_left", exp_q.size() + exp_mq.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [31:0] lsu_a [4] = '{32'h8000_2000, 32'h8000_3000, 32'h8000_2008, 32'h8000_200C};
  logic        lsu_w [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] lsu_d [4] = '{32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
  logic [3:0]  lsu_m [4] = '{4'hF, 4'hF, 4'h1, 4'hC};
  logic [31:0] ifu_a [2] = '{32'h8000_0000, 32'h8000_0004};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rcyc, n, li, ii;
    logic ai, al, seen;
    rst_n = 1'b0;
    ifu_req_valid = 0; ifu_addr = 0; ifu_resp_ready = 1;
    lsu_req_valid = 0; set_lsu(0, 0, 0, 0); lsu_resp_ready = 1;

    // ---- reset state -------------------------------------------------------
    @(negedge clk);
    chk("rst_valids", {mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid,
                       ifu_req_ready, lsu_req_ready}, 6'b0);
    chk("rst_fields", {mem_addr, mem_wdata, mem_mask, mem_wen}, 69'h0);
    ifu_req_valid = 1; #1;
    chk("rst_ifu_only_ready", {ifu_req_ready, lsu_req_ready}, 2'b10);
    lsu_req_valid = 1; #1;
    chk("rst_tie_ready", {ifu_req_ready, lsu_req_ready}, 2'b01);
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- both valid every cycle, four transactions -------------------------
`ifdef YSYX_23060075_ARB_RR_EN
    push_exp(1, 32'h8000_2000, 0, 32'h0, 4'hF, 32'h1111_2222);
    push_exp(0, 32'h8000_0000, 0, 32'h0, 4'hF, 32'h0000_0413);
    push_exp(1, 32'h8000_3000, 1, 32'hCAFE_F00D, 4'hF, 32'h0);
    push_exp(0, 32'h8000_0004, 0, 32'h0, 4'hF, 32'h0000_0513);
`else
    push_exp(1, 32'h8000_2000, 0, 32'h0, 4'hF, 32'h1111_2222);
    push_exp(1, 32'h8000_3000, 1, 32'hCAFE_F00D, 4'hF, 32'h0);
    push_exp(1, 32'h8000_2008, 0, 32'h0, 4'h1, 32'h5555_6666);
    push_exp(1, 32'h8000_200C, 0, 32'h0, 4'hC, 32'h7777_8888);
`endif
    n = 0; li = 0; ii = 0;
    ifu_addr = ifu_a[0]; ifu_req_valid = 1;
    set_lsu(lsu_a[0], lsu_w[0], lsu_d[0], lsu_m[0]); lsu_req_valid = 1;
    for (int t = 0; t < 200 && n < 4; t++) begin
      @(negedge clk);
      ai = ifu_req_valid && ifu_req_ready;
      al = lsu_req_valid && lsu_req_ready;
      @(posedge clk); #1;
      if (al) begin li++; n++; if (li < 4) set_lsu(lsu_a[li], lsu_w[li], lsu_d[li], lsu_m[li]); end
      if (ai) begin ii++; n++; if (ii < 2) ifu_addr = ifu_a[ii]; end
      if (n >= 4) begin ifu_req_valid = 0; lsu_req_valid = 0; end
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    chk("grant_count", n, 4);
    drain();

    // ---- IFU read alone, best-case latency ---------------------------------
    push_exp(0, 32'h8000_0000, 0, 32'h0, 4'hF, 32'h0000_0413);
    issue(0, 32'h8000_0000, 0, 0, 0, acc);
    seen = 0; rcyc = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (ifu_resp_valid) begin seen = 1; rcyc = cyc; end
    end
    chk("ifu_latency", rcyc - acc, 3);
    chk("ifu_resp_lsu_quiet", lsu_resp_valid, 1'b0);
    drain();

    // ---- LSU partial write --------------------------------------------------
    push_exp(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, 32'h0);
    issue(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'b0011, acc);
    drain();

    // ---- backpressure on both sides ----------------------------------------
    mem_rdy_en = 0;
    push_exp(0, 32'h8000_0004, 0, 32'h0, 4'hF, 32'h0000_0513);
    push_exp(1, 32'h8000_200C, 0, 32'h0, 4'hF, 32'h7777_8888);
    issue(0, 32'h8000_0004, 0, 0, 0, acc);
    set_lsu(32'h8000_200C, 0, 0, 4'hF); lsu_req_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_req_valid", mem_req_valid, 1'b1);
      chk("stall_no_accept", lsu_req_ready, 1'b0);
    end
    @(posedge clk); #1;
    mem_rdy_en = 1; ifu_resp_ready = 0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (ifu_resp_valid) seen = 1;
    end
    repeat (3) begin
      @(negedge clk);
      chk("resp_stall_valid", ifu_resp_valid, 1'b1);
      chk("resp_stall_no_accept", lsu_req_ready, 1'b0);
    end
    @(posedge clk); #1;
    ifu_resp_ready = 1;
    issue(1, 32'h8000_200C, 0, 0, 4'hF, acc);
    drain();

    // ---- spurious memory responses in IDLE and REQ --------------------------
    spur_data = 32'hFFFF_FFFF; spur_rv = 1;
    repeat (2) begin
      @(negedge clk);
      chk("spur_idle", {mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}, 4'b0);
    end
    @(posedge clk); #1;
    mem_rdy_en = 0;
    push_exp(1, 32'h8000_2004, 0, 32'h0, 4'hF, 32'h3333_4444);
    issue(1, 32'h8000_2004, 0, 0, 4'hF, acc);
    repeat (3) begin
      @(negedge clk);
      chk("spur_req", {mem_req_valid, mem_resp_ready, lsu_resp_valid}, 3'b100);
    end
    @(posedge clk); #1;
    spur_rv = 0; mem_rdy_en = 1;
    drain();

    // ---- reset during WAIT ------------------------------------------------
    mem_lat = 10;
    push_exp(0, 32'h8000_0000, 0, 32'h0, 4'hF, 32'h0000_0413);
    issue(0, 32'h8000_0000, 0, 0, 0, acc);
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (mem_resp_ready) seen = 1;
    end
    chk("reach_wait", seen, 1'b1);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valids", {mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid}, 4'b0);
    chk("async_rst_fields", {mem_addr, mem_mask}, 36'h0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; mem_lat = 0;
    repeat (12) @(posedge clk);
    #1;
    push_exp(0, 32'h8000_0000, 0, 32'h0, 4'hF, 32'h0000_0413);
    issue(0, 32'h8000_0000, 0, 0, 0, acc);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
